// File: rtl/sdram_rr_arbiter_pkg.sv
// Shared types and helpers for the SDRAM round-robin arbiter.
package dnn_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int tag_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// Bus bundle between the accelerator masters, the arbiter and the SDRAM
// controller slave. Requester-side signals are packed per slot.
interface sdram_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  logic [ADDR_W-1:0]         mem_address;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         mem_writedata;
  logic                      mem_waitrequest;
  logic [DATA_W-1:0]         mem_readdata;
  logic                      mem_readdatavalid;

  // Arbiter view: slave to the requesters, drives the memory command bus.
  modport slave (
    input  req_address, req_read, req_write, req_writedata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  // Environment view: the requesting masters plus the SDRAM controller.
  modport master (
    output req_address, req_read, req_write, req_writedata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );

endinterface

// File: rtl/sdram_rr_arbiter_tag_fifo.sv
// Tag FIFO holding the requester index of every outstanding read, in the
// order the SDRAM controller accepted them.
module dnn_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer/count update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared by reset so the FIFO always restarts empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage: contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave between NUM_REQ
// accelerator masters, with pipelined read-data return routed by tag.
module sdram_rr_arbiter
  import dnn_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_rr_arbiter_if.slave   bus,
  output logic                err
);

  localparam int TAG_W = tag_w(NUM_REQ);
  // Reset "last grant" to the highest index so requester 0 wins first.
  localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [TAG_W-1:0]   grant_q, grant_d;
  logic [TAG_W-1:0]   last_grant_q, last_grant_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] eligible;
  logic               sel_vld;
  logic [TAG_W-1:0]   sel_idx;
  logic               g_read, g_write;
  logic               accept, push, pop;
  logic               fifo_full, fifo_empty;
  logic [TAG_W-1:0]   fifo_head;

  // A read (read wins over write) needs tag FIFO room; a write is always eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_read[i] ? ~fifo_full : bus.req_write[i];
    end
  end

  // Cyclic search: first eligible index above last_grant, else first from 0.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld && eligible[i] && (TAG_W'(i) > last_grant_q)) begin
        sel_vld = 1'b1;
        sel_idx = TAG_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld && eligible[i]) begin
        sel_vld = 1'b1;
        sel_idx = TAG_W'(i);
      end
    end
  end

  // Granted-slot mux feeding the memory command bus.
  always_comb begin
    g_read            = 1'b0;
    g_write           = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == TAG_W'(i)) begin
        g_read            = bus.req_read[i];
        g_write           = bus.req_write[i];
        bus.mem_address   = bus.req_address[i*ADDR_W +: ADDR_W];
        bus.mem_writedata = bus.req_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Strobes only in GRANT; the granted master is released in the accept cycle only.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (state_q == GRANT) begin
      bus.mem_read  = g_read & ~fifo_full;
      bus.mem_write = g_write & ~g_read;
    end
    accept = (bus.mem_read | bus.mem_write) & ~bus.mem_waitrequest;
    bus.req_waitrequest = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (grant_q == TAG_W'(i))) begin
        bus.req_waitrequest[i] = 1'b0;
      end
    end
  end

  assign push = accept & bus.mem_read;
  assign pop  = bus.mem_readdatavalid & ~fifo_empty;

  // Read return: data passes straight through, strobe goes to the head tag owner.
  always_comb begin
    bus.req_readdata      = bus.mem_readdata;
    bus.req_readdatavalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop && (fifo_head == TAG_W'(i))) begin
        bus.req_readdatavalid[i] = 1'b1;
      end
    end
  end

  // Arbitration FSM next state plus sticky protocol-error accumulation.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (bus.mem_readdatavalid & fifo_empty) |
                   (accept & g_read & g_write);
    case (state_q)
      ARB: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          last_grant_d = grant_q;
          state_d      = ARB;
        end else if (!g_read && !g_write) begin
          // Master withdrew its request; rearbitrate without moving priority.
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State register; reset aborts any grant so strobes drop on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

  dnn_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_PEND)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (grant_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Scoreboard bench for sdram_rr_arbiter: directed stimulus pushes expected
// memory commands and read returns; a negedge monitor pops and compares.
module tb_sdram_rr_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_PEND = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  sdram_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  sdram_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int who; } mem_txn_t;
  typedef struct { int who; logic [31:0] data; } rd_txn_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  mem_txn_t exp_mem[$];
  rd_txn_t  exp_rd[$];
  rsp_t     rsp_q[$];

  int   lat = 3;
  logic spurious = 1'b0;
  int   first_ret_cyc = -1;
  int   acc, t0, acc9;

  mem_txn_t           mt;
  rd_txn_t            rt;
  logic [NUM_REQ-1:0] exp_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic expect_rd(input int who, input logic [31:0] addr);
    exp_mem.push_back('{1'b0, addr, 32'h0, who});
    exp_rd.push_back('{who, mem_val(addr)});
  endtask

  task automatic expect_wr(input int who, input logic [31:0] addr, input logic [31:0] data);
    exp_mem.push_back('{1'b1, addr, data, who});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one transfer on requester 'who' and hold it until accepted.
  task automatic rq(input int who, input logic rd, input logic wr,
                    input logic [31:0] addr, input logic [31:0] wdata, output int acc_cyc);
    bif.req_address[who*ADDR_W +: ADDR_W]   = addr;
    bif.req_writedata[who*DATA_W +: DATA_W] = wdata;
    bif.req_read[who]  = rd;
    bif.req_write[who] = wr;
    acc_cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bif.req_waitrequest[who]) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bif.req_read[who]  = 1'b0;
    bif.req_write[who] = 1'b0;
    if (acc_cyc < 0) fail_now("req_timeout");
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_mem.size() == 0 && exp_rd.size() == 0 && rsp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_exp_mem", exp_mem.size(), 0);
    check("drain_exp_rd", exp_rd.size(), 0);
    step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // SDRAM read-data model: returns each accepted read 'lat' cycles later.
  initial begin
    bif.mem_readdatavalid = 1'b0;
    bif.mem_readdata      = '0;
    forever begin
      @(posedge clk);
      #2;
      bif.mem_readdatavalid = 1'b0;
      bif.mem_readdata      = 32'h0BAD_0BAD;
      if (spurious) begin
        bif.mem_readdatavalid = 1'b1;
        bif.mem_readdata      = 32'h5A5A_5A5A;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        bif.mem_readdatavalid = 1'b1;
        bif.mem_readdata      = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
    end
  end

  // Monitor: compare every accepted command and every read return.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((bif.mem_read || bif.mem_write) && !bif.mem_waitrequest) begin
        if (bif.mem_read) rsp_q.push_back('{cyc + lat, mem_val(bif.mem_address)});
        if (exp_mem.size() == 0) begin
          fail_now("mem_cmd_unexpected");
        end else begin
          mt = exp_mem.pop_front();
          exp_vec = '1;
          exp_vec[mt.who] = 1'b0;
          check("mem_write", bif.mem_write, mt.we);
          check("mem_read", bif.mem_read, !mt.we);
          check("mem_address", bif.mem_address, mt.addr);
          check("grant_owner", bif.req_waitrequest, exp_vec);
          if (mt.we) check("mem_writedata", bif.mem_writedata, mt.data);
        end
      end
      if (bif.req_readdatavalid != '0) begin
        if (first_ret_cyc < 0) first_ret_cyc = cyc;
        if (exp_rd.size() == 0) begin
          fail_now("rdv_unexpected");
        end else begin
          rt = exp_rd.pop_front();
          exp_vec = '0;
          exp_vec[rt.who] = 1'b1;
          check("rdv_owner", bif.req_readdatavalid, exp_vec);
          check("rd_data", bif.req_readdata, rt.data);
        end
      end
    end
  end

  initial begin
    bif.req_address     = '0;
    bif.req_read        = '0;
    bif.req_write       = '0;
    bif.req_writedata   = '0;
    bif.mem_waitrequest = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_waitrequest", bif.req_waitrequest, 2'b11);
    check("rst_rdv", bif.req_readdatavalid, 2'b00);
    check("rst_mem_read", bif.mem_read, 0);
    check("rst_mem_write", bif.mem_write, 0);
    check("rst_err", err, 0);
    check("rst_fifo_count", dut.u_fifo.count_q, 0);
    rst_n = 1'b1;
    step();

    // Contention: grants alternate starting with requester 0
    lat = 3;
    expect_rd(0, 32'h200);
    expect_rd(1, 32'h300);
    expect_rd(0, 32'h204);
    expect_rd(1, 32'h304);
    fork
      begin int a; rq(0, 1'b1, 1'b0, 32'h200, 32'h0, a); rq(0, 1'b1, 1'b0, 32'h204, 32'h0, a); end
      begin int b; rq(1, 1'b1, 1'b0, 32'h300, 32'h0, b); rq(1, 1'b1, 1'b0, 32'h304, 32'h0, b); end
    join
    drain();

    // Single write: accepted in the cycle after the request appears
    expect_wr(0, 32'h100, 32'hDEAD_BEEF);
    t0 = cyc;
    rq(0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, acc);
    check("t1_write_latency", acc, t0 + 1);
    drain();

    // Pipelined reads fill the tag FIFO; 9th read waits for the first return
    lat = 20;
    first_ret_cyc = -1;
    for (int i = 0; i < 9; i++) expect_rd(1, 32'h1000 + 32'(4 * i));
    for (int i = 0; i < 9; i++) begin
      rq(1, 1'b1, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, acc);
      if (i == 7) check("t3_fifo_full_count", dut.u_fifo.count_q, 8);
      if (i == 8) acc9 = acc;
    end
    check("t3_ninth_after_return", acc9, first_ret_cyc + 2);
    drain();

    // Push and pop in the same cycle keep the count at 3
    lat = 6;
    for (int i = 0; i < 5; i++) expect_rd(0, 32'h2000 + 32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      rq(0, 1'b1, 1'b0, 32'h2000 + 32'(4 * i), 32'h0, acc);
      if (i == 2) check("t4_count_before", dut.u_fifo.count_q, 3);
      if (i == 3) check("t4_count_after_pushpop", dut.u_fifo.count_q, 3);
    end
    drain();

    // Spurious read data with an empty FIFO
    lat = 3;
    check("t5_err_clear", err, 0);
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    @(negedge clk);
    check("t5_spurious_no_rdv", bif.req_readdatavalid, 2'b00);
    @(negedge clk);
    check("t5_spurious_err", err, 1);
    step();
    reset_dut();
    check("t5_err_after_reset", err, 0);

    // Read and write together: issued as a read, flagged
    expect_rd(0, 32'h500);
    rq(0, 1'b1, 1'b1, 32'h500, 32'h1234_5678, acc);
    check("t5_rw_err", err, 1);
    drain();

    // Reset while stalled in GRANT with a read outstanding
    lat = 50;
    exp_mem.push_back('{1'b0, 32'h600, 32'h0, 1});
    rq(1, 1'b1, 1'b0, 32'h600, 32'h0, acc);
    check("t6_count_before", dut.u_fifo.count_q, 1);
    bif.mem_waitrequest = 1'b1;
    bif.req_address[0 +: ADDR_W] = 32'h700;
    bif.req_read[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bif.mem_read) break;
    end
    check("t6_in_grant", bif.mem_read, 1);
    step();
    rst_n = 1'b0;
    step();
    check("t6_mem_read_dropped", bif.mem_read, 0);
    check("t6_waitrequest", bif.req_waitrequest, 2'b11);
    check("t6_fifo_empty", dut.u_fifo.count_q, 0);
    check("t6_err", err, 0);
    bif.req_read = '0;
    bif.mem_waitrequest = 1'b0;
    rsp_q.delete();
    exp_rd.delete();
    step();
    rst_n = 1'b1;
    step();

    // Normal operation after reset
    lat = 3;
    expect_rd(1, 32'h800);
    rq(1, 1'b1, 1'b0, 32'h800, 32'h0, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
